// File: rtl/neuron_spike_out_fifo_if.sv
// rtl/neuron_spike_out_fifo_if.sv - Wishbone slave bus bundle for the spike output FIFO
//
// Purpose: groups the Wishbone classic signals used to reach the spike FIFO
//          register/frame window.
// Signals:
//   wbs_cyc_i, wbs_stb_i, wbs_we_i  cycle, strobe, write enable (master -> slave)
//   wbs_sel_i[3:0]                  byte selects               (master -> slave)
//   wbs_adr_i[31:0]                 byte address               (master -> slave)
//   wbs_dat_i[31:0]                 write data                 (master -> slave)
//   wbs_ack_o                       acknowledge                (slave -> master)
//   wbs_dat_o[31:0]                 read data                  (slave -> master)

interface neuron_spike_out_fifo_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/neuron_spike_out_fifo.sv
// rtl/neuron_spike_out_fifo.sv - frame-wide spike output FIFO with Wishbone readout
//
// Purpose: buffers up to DEPTH spike frames (NUM_NEURONS bits each) pushed by the
//          neuron core. Firmware reads the head frame word by word through a
//          Wishbone window and pops it through CTRL. Provides occupancy status,
//          sticky overflow, flush and a level interrupt.
// Ports:
//   wb_clk_i               clock, all logic on posedge
//   wb_rst_i               asynchronous active-high reset
//   wb                     Wishbone slave bundle (neuron_spike_out_fifo_if.slave)
//   external_spike_data_i  spike frame from core, bit n = neuron n
//   external_write_en_i    one-cycle push strobe
//   fifo_full_o            count == DEPTH
//   irq_o                  irq_en && count != 0
//
// Register map (offset from BASE_ADDR):
//   0x000..4*(WORDS-1)  FRAME window (RO), word k = head frame bits [32k+31:32k]
//   0x800               STATUS (RO): [CW-1:0] count, [16] empty, [17] full,
//                       [18] overflow, [24] irq_en
//   0x804               CTRL: wr bit0 pop, bit1 clear overflow, bit2 flush (sel[0]),
//                       bit8 irq_en (sel[1]); rd returns irq_en at bit8

module neuron_spike_out_fifo #(
    parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
    parameter int          NUM_NEURONS = 256,
    parameter int          DEPTH       = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    neuron_spike_out_fifo_if.slave wb,
    input  logic [NUM_NEURONS-1:0] external_spike_data_i,
    input  logic                   external_write_en_i,
    output logic                   fifo_full_o,
    output logic                   irq_o
);

    localparam int WORDS = NUM_NEURONS / 32;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [31:0] STATUS_OFS = 32'h0000_0800;
    localparam logic [31:0] CTRL_OFS   = 32'h0000_0804;
    localparam logic [31:0] FRAME_END  = 32'(4 * WORDS);

    // Frame storage (deliberately not reset)
    logic [NUM_NEURONS-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq_en;

    logic          empty;
    logic          full;

    // Bus decode
    logic [31:0]   offset;
    logic          req;
    logic          frame_hit;
    logic          status_hit;
    logic          ctrl_hit;
    logic [WIW-1:0] word_idx;

    logic [NUM_NEURONS-1:0] head;
    logic [NUM_NEURONS-1:0] head_sh;
    logic [31:0]   status_word;
    logic [31:0]   rdata;

    // Control decode
    logic          ctrl_wr;
    logic          pop_req;
    logic          clr_ovf;
    logic          flush;
    logic          irq_wr;

    // FIFO actions for this cycle
    logic          do_pop;
    logic          do_push;
    logic          ovf_set;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign fifo_full_o = full;
    assign irq_o       = irq_en && !empty;

    // A request is accepted only while ack is low, so every transfer produces
    // exactly one ack pulse and one side effect, even if stb is held high.
    assign req = wb.wbs_cyc_i && wb.wbs_stb_i && !wb.wbs_ack_o;

    assign offset     = wb.wbs_adr_i - BASE_ADDR;
    assign frame_hit  = (offset[1:0] == 2'b00) && (offset < FRAME_END);
    assign status_hit = (offset == STATUS_OFS);
    assign ctrl_hit   = (offset == CTRL_OFS);
    assign word_idx   = offset[WIW+1:2];

    // Head frame word select: shift the selected 32-bit word down to bit 0.
    assign head    = mem[rd_ptr];
    assign head_sh = head >> {word_idx, 5'd0};

    assign status_word = {7'd0, irq_en, 5'd0, overflow, full, empty,
                          {(16 - CW){1'b0}}, count};

    always_comb begin
        rdata = '0;
        if (frame_hit) begin
            if (!empty) begin
                rdata = head_sh[31:0];
            end
        end else if (status_hit) begin
            rdata = status_word;
        end else if (ctrl_hit) begin
            rdata = {23'd0, irq_en, 8'd0};
        end
    end

    assign ctrl_wr = req && wb.wbs_we_i && ctrl_hit;
    assign pop_req = ctrl_wr && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
    assign clr_ovf = ctrl_wr && wb.wbs_sel_i[0] && wb.wbs_dat_i[1];
    assign flush   = ctrl_wr && wb.wbs_sel_i[0] && wb.wbs_dat_i[2];
    assign irq_wr  = ctrl_wr && wb.wbs_sel_i[1];

    // Flush wins over everything: a coincident push is silently discarded.
    // A push into a full FIFO still lands when a pop frees the head slot in
    // the same cycle; a pop on an empty FIFO is ignored.
    assign do_pop  = pop_req && !flush && !empty;
    assign do_push = external_write_en_i && !flush && (!full || do_pop);
    assign ovf_set = external_write_en_i && !flush && full && !do_pop;

    // Bus response
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
        end else begin
            wb.wbs_ack_o <= req;
            if (req) begin
                wb.wbs_dat_o <= rdata;
            end
        end
    end

    // FIFO bookkeeping
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new overflow beats a coincident clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en <= 1'b0;
        end else if (irq_wr) begin
            irq_en <= wb.wbs_dat_i[8];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= external_spike_data_i;
        end
    end

    // Write-data and byte-select bits with no register behind them.
    logic unused_bits;
    assign unused_bits = &{1'b0, wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:9], wb.wbs_dat_i[7:3]};

endmodule

// File: doc/neuron_spike_out_fifo.md
Name: neuron_spike_out_fifo

Overview:
- Parametrised spike-output buffer for a neuron core; holds up to DEPTH complete spike frames of NUM_NEURONS bits each, one frame per timestep.
- The core pushes whole frames. Firmware reads the head frame word-by-word over Wishbone, then pops it through a control register.
- Adds occupancy/status reporting, sticky overflow, flush and a level interrupt, so firmware need not service every timestep.

Parameters:
- BASE_ADDR, 32'h50000000, Wishbone base address of the block.
- NUM_NEURONS, 256, spike frame width in bits; multiple of 32, range 32..8192.
- DEPTH, 4, frame slots; power of 2, range 2..128.
- Derived, not overridable: WORDS = NUM_NEURONS/32; CW = $clog2(DEPTH+1).

Ports:
- wb_clk_i  in  1  clock; all logic on posedge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- external_spike_data_i  in  NUM_NEURONS  spike frame from core; bit n = neuron n.
- external_write_en_i  in  1  one-cycle push strobe.
- fifo_full_o  out  1  count == DEPTH.
- irq_o  out  1  level interrupt: irq_en && count != 0.

Behaviour:
- Interface: single clock wb_clk_i; reset wb_rst_i is asynchronous and active-high.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, count=0, rd_ptr=wr_ptr=0, overflow=0, irq_en=0, fifo_full_o=0, irq_o=0. Frame storage is not reset.
- Address map, offset = wbs_adr_i - BASE_ADDR:
  - 0x000..4*(WORDS-1): FRAME window, read-only. Word k = head frame bits [32k+31:32k].
  - 0x800: STATUS, read-only. [CW-1:0] count, [16] empty, [17] full, [18] overflow, [24] irq_en.
  - 0x804: CTRL. Write bit0=pop, bit1=clear overflow, bit2=flush (all require sel[0]); bit8=irq_en (requires sel[1]). Reads return irq_en at bit8, 0 elsewhere.
  - Any other offset, including FRAME words >= WORDS: write ignored, read returns 0, still acked.
- Handshake:
  - When cyc&&stb&&!ack, the next posedge sets ack=1 and loads wbs_dat_o; the following posedge clears ack. Result: one-cycle ack, latency 1, no back-to-back ack.
  - Side effects occur on the ack edge only, so each transfer has exactly one effect.
  - wbs_dat_o holds its value when ack=0.
- Reads: FRAME reads while empty return 0. Reads never pop.
- Push (external_write_en_i=1): frame written to slot wr_ptr; wr_ptr increments mod DEPTH; count+1.
- Pop (CTRL write, bit0): rd_ptr increments mod DEPTH; count-1. Pop while empty has no effect.
- Full: a push with no simultaneous pop is dropped and sets overflow. Stored data is unchanged.
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - When full, the push succeeds and overflow is not set.
  - When empty, the pop is ignored and the push succeeds (count becomes 1).
- Flush (CTRL write, bit2): count=0, rd_ptr=wr_ptr=0. A push in the same cycle is discarded and does not set overflow. Flush has priority over pop.
- Overflow: sticky. Cleared by a CTRL write with bit1. If clear and a new overflow coincide, overflow remains set.
- Pointer wrap is mod DEPTH; count saturates logically at DEPTH via the full rule.
- fifo_full_o and irq_o are combinational from registered state; no glitch paths from bus inputs.
- Reset mid-transaction: ack and dat_o drop immediately and all frames are lost (count=0). The master must retry.

Test Plan:
- Reset, then read STATUS -> ack one cycle later; data=0x00010000 (empty=1); irq_o=0; fifo_full_o=0.
- Push frame with word0=0xDEADBEEF, word7=0x80000001 (NUM_NEURONS=256); read offsets 0x000 and 0x01C -> 0xDEADBEEF and 0x80000001; STATUS count=1; reads leave count=1.
- Push 4 frames (DEPTH=4), then push a 5th -> fifo_full_o=1, STATUS=0x00060004; head still frame 1; write CTRL=0x2 -> overflow clears, count stays 4.
- With the FIFO full, push and pop in the same cycle -> count stays 4, overflow=0, head becomes frame 2. Pop until empty, then pop again -> count stays 0, no error.
- Write CTRL=0x100, push one frame -> irq_o=1. Write CTRL=0x104 (flush) while pushing in the same cycle -> count=0, irq_o=0, overflow=0.
- Read 0x100 and 0xC00; write 0x000 -> each acked in one cycle, reads=0, FRAME contents unchanged. Assert wb_rst_i during an ack -> ack=0 and count=0 immediately.
